// File: rtl/char_text_streamer_pkg.sv
// Shared constants and character helpers for the char_rom text dump path.
package char_text_streamer_pkg;

    localparam int unsigned CHAR_ROWS   = 16;
    localparam int unsigned CHAR_COLS   = 16;
    localparam logic [7:0]  ASCII_CR    = 8'h0D;
    localparam logic [7:0]  ASCII_LF    = 8'h0A;
    localparam logic [6:0]  ASCII_SPACE = 7'h20;
    localparam logic [7:0]  ASCII_SUBST = 8'h3F;

    function automatic logic is_blank(input logic [6:0] c);
        return (c == 7'h00) || (c == ASCII_SPACE);
    endfunction

    // NUL prints as a space, other control codes as '?'.
    function automatic logic [7:0] to_tx_byte(input logic [6:0] c);
        if (c == 7'h00)
            return {1'b0, ASCII_SPACE};
        else if (c < ASCII_SPACE)
            return ASCII_SUBST;
        else
            return {1'b0, c};
    endfunction

endpackage

// File: rtl/char_text_streamer_if.sv
// Byte stream towards the UART transmitter (valid/ready handshake).
interface char_text_streamer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/char_text_streamer_line_buf.sv
// One text row of char_rom codes, with the trim point (last non-blank column)
// and the all-blank flag kept alongside.
module char_line_buf
    import char_text_streamer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_idx,
    input  logic [6:0] i_wr_data,
    input  logic [3:0] i_rd_idx,
    output logic [6:0] o_rd_data,
    output logic [3:0] o_last,
    output logic       o_empty
);

    logic [6:0] r_buf [CHAR_COLS];
    logic [3:0] r_last;
    logic       r_empty;

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_buf[i_wr_idx] <= i_wr_data;
    end

    // Columns arrive in ascending order, so last/empty are settled once the
    // final column is written and the SCAN cycle can decide on them directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= '0;
            r_empty <= 1'b1;
        end else if (i_wr_en) begin
            if (i_wr_idx == '0) begin
                r_last  <= '0;
                r_empty <= is_blank(i_wr_data);
            end else if (!is_blank(i_wr_data)) begin
                r_last  <= i_wr_idx;
                r_empty <= 1'b0;
            end
        end
    end

    assign o_rd_data = r_buf[i_rd_idx];
    assign o_last    = r_last;
    assign o_empty   = r_empty;

endmodule

// File: rtl/char_text_streamer.sv
// Dumps rows of the char_rom text table to the UART as trimmed ASCII lines
// terminated with CR LF.
module char_text_streamer
    import char_text_streamer_pkg::*;
#(
    parameter int unsigned NUM_LINES   = 9,
    parameter int unsigned LINE_LEN    = 16,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [7:0]            char_xy,
    input  logic [6:0]            char_code,
    char_text_streamer_if.master  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned FETCH_CYCLES = LINE_LEN + ROM_LATENCY;
    localparam int unsigned CW           = $clog2(FETCH_CYCLES + 1);
    localparam logic [3:0]  LAST_ROW     = 4'(NUM_LINES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCAN,
        EMIT,
        CR,
        LF,
        FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_row;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [7:0]    r_char_xy;
    logic          r_busy;

    logic          w_xfer;
    logic          w_fetch_last;
    logic          w_wr_en;
    logic [3:0]    w_wr_idx;
    logic [6:0]    w_rd_data;
    logic [3:0]    w_last;
    logic          w_empty;

    assign w_xfer       = tx.tx_valid && tx.tx_ready;
    assign w_fetch_last = (r_cnt == CW'(FETCH_CYCLES - 1));
    // ROM data lags the address by ROM_LATENCY cycles of the fetch counter.
    assign w_wr_en      = (r_state == FETCH) && (r_cnt >= CW'(ROM_LATENCY));
    assign w_wr_idx     = 4'(r_cnt - CW'(ROM_LATENCY));

    char_line_buf u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (char_code),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data),
        .o_last    (w_last),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (w_fetch_last) w_next = SCAN;
            SCAN:    w_next = w_empty ? CR : EMIT;
            EMIT:    if (w_xfer && (r_idx == w_last)) w_next = CR;
            CR:      if (w_xfer) w_next = LF;
            LF:      if (w_xfer) w_next = (r_row == LAST_ROW) ? FINISH : FETCH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_char_xy <= '0;
            r_busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row     <= '0;
                        r_cnt     <= '0;
                        r_char_xy <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt < CW'(LINE_LEN - 1))
                        r_char_xy <= {r_row, 4'(r_cnt + CW'(1))};
                end
                SCAN: r_idx <= '0;
                EMIT: begin
                    if (w_xfer)
                        r_idx <= r_idx + 4'd1;
                end
                LF: begin
                    if (w_xfer && (r_row != LAST_ROW)) begin
                        r_row     <= r_row + 4'd1;
                        r_cnt     <= '0;
                        r_char_xy <= {r_row + 4'd1, 4'd0};
                    end
                end
                FINISH: begin
                    r_busy    <= 1'b0;
                    r_char_xy <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        done        = 1'b0;
        unique case (r_state)
            EMIT: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = to_tx_byte(w_rd_data);
            end
            CR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = ASCII_CR;
            end
            LF: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = ASCII_LF;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    assign char_xy = r_char_xy;
    assign busy    = r_busy;

endmodule
